// File: rtl/pu_alu_seq.sv
// pu_alu_seq: job sequencer for the PU post-processing ALU.
//
// Accepts one descriptor per cfg_valid/cfg_ready handshake. It loads the ALU
// shift register, streams N obuf reads through the ALU and writes each result
// back starting at a second base address.
//
// Ports
//   clk, reset          clock, asynchronous active-high reset
//   cfg_*               job descriptor (fn, imm, rshift, 8bit, num, rd/wr base)
//   cfg_ready           descriptor accepted while high (IDLE only)
//   stall               holds off new reads; in-flight elements still complete
//   obuf_rd_req/addr    read strobe/address, data returns one cycle later
//   alu_*               ALU function, immediate, mode and shift-register load
//   obuf_wr_en/addr     write strobe/address, data is alu_out in that cycle
//   busy, done          not-IDLE flag and one-cycle end-of-job pulse
//
// state  | meaning
// -------+--------------------------------------------------------------
// IDLE   | waiting for a descriptor, cfg_ready high
// LOAD   | one cycle, pulses the ALU shift-register load
// ISSUE  | one read per unstalled cycle until N reads are issued
// DRAIN  | no reads, waiting for the last write to leave the ALU pipe
// DONE   | one cycle, done pulse
module pu_alu_seq #(
   parameter int FN_WIDTH   = 3,
   parameter int IMM_WIDTH  = 16,
   parameter int ADDR_WIDTH = 16,
   parameter int NUM_WIDTH  = 16
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  cfg_valid,
   output logic                  cfg_ready,
   input  logic [FN_WIDTH-1:0]   cfg_fn,
   input  logic [IMM_WIDTH-1:0]  cfg_imm,
   input  logic [IMM_WIDTH-1:0]  cfg_rshift,
   input  logic                  cfg_8bit,
   input  logic [NUM_WIDTH-1:0]  cfg_num,
   input  logic [ADDR_WIDTH-1:0] cfg_rd_base,
   input  logic [ADDR_WIDTH-1:0] cfg_wr_base,
   input  logic                  stall,
   output logic                  obuf_rd_req,
   output logic [ADDR_WIDTH-1:0] obuf_rd_addr,
   output logic                  alu_fn_valid,
   output logic [FN_WIDTH-1:0]   alu_fn,
   output logic [IMM_WIDTH-1:0]  alu_imm,
   output logic                  alu_choose_8bit,
   output logic                  alu_cfg_rs_num_v,
   output logic [IMM_WIDTH-1:0]  alu_rshift_num,
   output logic                  obuf_wr_en,
   output logic [ADDR_WIDTH-1:0] obuf_wr_addr,
   output logic                  busy,
   output logic                  done
);

   localparam int CW = NUM_WIDTH + 1;

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_LOAD  = 3'd1,
      S_ISSUE = 3'd2,
      S_DRAIN = 3'd3,
      S_DONE  = 3'd4
   } state_t;

   state_t state, state_nxt;

   logic [FN_WIDTH-1:0]   fn_q;
   logic [IMM_WIDTH-1:0]  imm_q;
   logic [IMM_WIDTH-1:0]  rshift_q;
   logic                  b8_q;
   logic [NUM_WIDTH-1:0]  num_q;
   logic [ADDR_WIDTH-1:0] rd_base_q;
   logic [ADDR_WIDTH-1:0] wr_base_q;
   logic [NUM_WIDTH-1:0]  rd_cnt;
   logic [NUM_WIDTH-1:0]  wr_cnt;
   logic                  fn_valid_q;
   logic                  pipe_q;
   logic                  wr_en_q;

   logic accept;
   logic rd_req;
   logic last_rd;
   logic last_wr;

   assign accept = (state == S_IDLE) && cfg_valid;
   assign rd_req = (state == S_ISSUE) && !stall;

   // Compares run one bit wider so N = 2^NUM_WIDTH-1 cannot overflow.
   assign last_rd = rd_req && (({1'b0, rd_cnt} + CW'(1)) == {1'b0, num_q});
   // True in the cycle of the Nth write, so DONE follows it directly.
   assign last_wr = (({1'b0, wr_cnt} + CW'(wr_en_q)) == {1'b0, num_q});

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state <= S_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE:  if (cfg_valid) state_nxt = S_LOAD;
         S_LOAD:  state_nxt = (num_q == '0) ? S_DONE : S_ISSUE;
         S_ISSUE: if (last_rd) state_nxt = S_DRAIN;
         S_DRAIN: if (last_wr) state_nxt = S_DONE;
         S_DONE:  state_nxt = S_IDLE;
         default: state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         fn_q      <= '0;
         imm_q     <= '0;
         rshift_q  <= '0;
         b8_q      <= 1'b0;
         num_q     <= '0;
         rd_base_q <= '0;
         wr_base_q <= '0;
      end else if (accept) begin
         fn_q      <= cfg_fn;
         imm_q     <= cfg_imm;
         rshift_q  <= cfg_rshift;
         b8_q      <= cfg_8bit;
         num_q     <= cfg_num;
         rd_base_q <= cfg_rd_base;
         wr_base_q <= cfg_wr_base;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         rd_cnt <= '0;
         wr_cnt <= '0;
      end else if (accept) begin
         rd_cnt <= '0;
         wr_cnt <= '0;
      end else begin
         if (rd_req)  rd_cnt <= rd_cnt + NUM_WIDTH'(1);
         if (wr_en_q) wr_cnt <= wr_cnt + NUM_WIDTH'(1);
      end
   end

   // Read -> fn_valid (data return) -> ALU fn reg -> ALU output reg = write.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         fn_valid_q <= 1'b0;
         pipe_q     <= 1'b0;
         wr_en_q    <= 1'b0;
      end else begin
         fn_valid_q <= rd_req;
         pipe_q     <= fn_valid_q;
         wr_en_q    <= pipe_q;
      end
   end

   assign cfg_ready        = (state == S_IDLE);
   assign busy             = (state != S_IDLE);
   assign done             = (state == S_DONE);
   assign alu_cfg_rs_num_v = (state == S_LOAD);
   assign alu_rshift_num   = rshift_q;
   assign alu_fn           = fn_q;
   assign alu_imm          = imm_q;
   assign alu_choose_8bit  = b8_q;
   assign alu_fn_valid     = fn_valid_q;
   assign obuf_rd_req      = rd_req;
   assign obuf_rd_addr     = rd_base_q + ADDR_WIDTH'(rd_cnt);
   assign obuf_wr_en       = wr_en_q;
   assign obuf_wr_addr     = wr_base_q + ADDR_WIDTH'(wr_cnt);

endmodule

// File: tb/tb_pu_alu_seq.sv
module tb_pu_alu_seq;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        cfg_valid = 1'b0;
   logic        cfg_ready;
   logic [2:0]  cfg_fn = '0;
   logic [15:0] cfg_imm = '0;
   logic [15:0] cfg_rshift = '0;
   logic        cfg_8bit = 1'b0;
   logic [15:0] cfg_num = '0;
   logic [15:0] cfg_rd_base = '0;
   logic [15:0] cfg_wr_base = '0;
   logic        stall = 1'b0;
   logic        obuf_rd_req;
   logic [15:0] obuf_rd_addr;
   logic        alu_fn_valid;
   logic [2:0]  alu_fn;
   logic [15:0] alu_imm;
   logic        alu_choose_8bit;
   logic        alu_cfg_rs_num_v;
   logic [15:0] alu_rshift_num;
   logic        obuf_wr_en;
   logic [15:0] obuf_wr_addr;
   logic        busy;
   logic        done;

   int checks = 0;
   int failures = 0;

   int          rd_cyc[$];
   logic [15:0] rd_adr[$];
   int          wr_cyc[$];
   logic [15:0] wr_adr[$];
   int          fv_cyc[$];
   int          rs_cyc[$];
   int          done_cyc[$];
   int          ready_cyc;
   int          attr_bad;

   pu_alu_seq dut (
      .clk(clk), .reset(reset),
      .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
      .cfg_fn(cfg_fn), .cfg_imm(cfg_imm), .cfg_rshift(cfg_rshift),
      .cfg_8bit(cfg_8bit), .cfg_num(cfg_num),
      .cfg_rd_base(cfg_rd_base), .cfg_wr_base(cfg_wr_base),
      .stall(stall),
      .obuf_rd_req(obuf_rd_req), .obuf_rd_addr(obuf_rd_addr),
      .alu_fn_valid(alu_fn_valid), .alu_fn(alu_fn), .alu_imm(alu_imm),
      .alu_choose_8bit(alu_choose_8bit), .alu_cfg_rs_num_v(alu_cfg_rs_num_v),
      .alu_rshift_num(alu_rshift_num),
      .obuf_wr_en(obuf_wr_en), .obuf_wr_addr(obuf_wr_addr),
      .busy(busy), .done(done)
   );

   always #5 clk = ~clk;

   // Submits one descriptor (accepted at edge 0) and records cycles 1..kmax.
   task automatic run_job(input int n, input logic [15:0] rb, input logic [15:0] wb,
                          input logic [2:0] fn, input logic [15:0] imm,
                          input logic [15:0] rsh, input logic b8,
                          input logic [63:0] smask, input int kmax);
      rd_cyc.delete(); rd_adr.delete(); wr_cyc.delete(); wr_adr.delete();
      fv_cyc.delete(); rs_cyc.delete(); done_cyc.delete();
      ready_cyc = -1;
      attr_bad = 0;
      @(negedge clk);
      cfg_fn = fn; cfg_imm = imm; cfg_rshift = rsh; cfg_8bit = b8;
      cfg_num = 16'(n); cfg_rd_base = rb; cfg_wr_base = wb;
      cfg_valid = 1'b1;
      @(posedge clk);
      #1 cfg_valid = 1'b0;
      for (int k = 1; k <= kmax; k++) begin
         stall = smask[k];
         @(negedge clk);
         if (obuf_rd_req) begin rd_cyc.push_back(k); rd_adr.push_back(obuf_rd_addr); end
         if (obuf_wr_en) begin wr_cyc.push_back(k); wr_adr.push_back(obuf_wr_addr); end
         if (alu_fn_valid) fv_cyc.push_back(k);
         if (alu_cfg_rs_num_v) begin
            rs_cyc.push_back(k);
            if (alu_rshift_num !== rsh) attr_bad++;
         end
         if (done) done_cyc.push_back(k);
         if (cfg_ready && ready_cyc < 0) ready_cyc = k;
         if (alu_fn !== fn || alu_imm !== imm || alu_choose_8bit !== b8) attr_bad++;
         @(posedge clk);
         #1;
      end
      stall = 1'b0;
   endtask

   task automatic test_reset();
      @(negedge clk);
      checks++;
      if ({obuf_rd_req, obuf_rd_addr, alu_fn_valid, alu_fn, alu_imm, alu_choose_8bit,
           alu_cfg_rs_num_v, alu_rshift_num, obuf_wr_en, obuf_wr_addr, busy, done} !== '0) begin
         failures++;
         $display("FAIL reset_outputs: got rd=%b wr=%b fv=%b busy=%b done=%b fn=%0d, want all zero",
                  obuf_rd_req, obuf_wr_en, alu_fn_valid, busy, done, alu_fn);
      end
      checks++;
      if (cfg_ready !== 1'b1) begin
         failures++;
         $display("FAIL reset_cfg_ready: got %b want 1", cfg_ready);
      end
      reset = 1'b0;
   endtask

   task automatic test_basic();
      int e_rd[4] = '{2, 3, 4, 5};
      int e_wr[4] = '{5, 6, 7, 8};
      run_job(4, 16'h0010, 16'h0080, 3'd3, 16'd2, 16'd1, 1'b1, 64'h0, 14);
      checks++;
      if (rs_cyc.size() !== 1 || rs_cyc[0] !== 1) begin
         failures++;
         $display("FAIL basic_load: got %0d pulses first=%0d want 1 at cycle 1", rs_cyc.size(), rs_cyc[0]);
      end
      checks++;
      if (rd_cyc.size() !== 4 || wr_cyc.size() !== 4) begin
         failures++;
         $display("FAIL basic_counts: got rd=%0d wr=%0d want 4/4", rd_cyc.size(), wr_cyc.size());
      end
      for (int i = 0; i < 4 && i < rd_cyc.size(); i++) begin
         checks++;
         if (rd_cyc[i] !== e_rd[i] || rd_adr[i] !== 16'h0010 + 16'(i)) begin
            failures++;
            $display("FAIL basic_read%0d: got cyc=%0d addr=%h want cyc=%0d addr=%h",
                     i, rd_cyc[i], rd_adr[i], e_rd[i], 16'h0010 + 16'(i));
         end
      end
      for (int i = 0; i < 4 && i < wr_cyc.size(); i++) begin
         checks++;
         if (wr_cyc[i] !== e_wr[i] || wr_adr[i] !== 16'h0080 + 16'(i)) begin
            failures++;
            $display("FAIL basic_write%0d: got cyc=%0d addr=%h want cyc=%0d addr=%h",
                     i, wr_cyc[i], wr_adr[i], e_wr[i], 16'h0080 + 16'(i));
         end
      end
      checks++;
      if (fv_cyc.size() !== 4 || fv_cyc[0] !== 3 || fv_cyc[3] !== 6) begin
         failures++;
         $display("FAIL basic_fn_valid: got n=%0d first=%0d want 4 in cycles 3..6", fv_cyc.size(), fv_cyc[0]);
      end
      checks++;
      if (done_cyc.size() !== 1 || done_cyc[0] !== 9 || ready_cyc !== 10) begin
         failures++;
         $display("FAIL basic_done: got n=%0d at %0d ready at %0d want done 9 ready 10",
                  done_cyc.size(), done_cyc[0], ready_cyc);
      end
      checks++;
      if (attr_bad !== 0) begin
         failures++;
         $display("FAIL basic_alu_static: got %0d bad cycles want 0", attr_bad);
      end
   endtask

   task automatic test_stall();
      int e_rd[4] = '{2, 5, 6, 7};
      int e_wr[4] = '{5, 8, 9, 10};
      run_job(4, 16'h0010, 16'h0080, 3'd3, 16'd2, 16'd1, 1'b1, 64'h18, 16);
      checks++;
      if (rd_cyc.size() !== 4 || wr_cyc.size() !== 4) begin
         failures++;
         $display("FAIL stall_counts: got rd=%0d wr=%0d want 4/4", rd_cyc.size(), wr_cyc.size());
      end
      for (int i = 0; i < 4 && i < rd_cyc.size(); i++) begin
         checks++;
         if (rd_cyc[i] !== e_rd[i] || rd_adr[i] !== 16'h0010 + 16'(i)) begin
            failures++;
            $display("FAIL stall_read%0d: got cyc=%0d addr=%h want cyc=%0d", i, rd_cyc[i], rd_adr[i], e_rd[i]);
         end
      end
      for (int i = 0; i < 4 && i < wr_cyc.size(); i++) begin
         checks++;
         if (wr_cyc[i] !== e_wr[i] || wr_adr[i] !== 16'h0080 + 16'(i)) begin
            failures++;
            $display("FAIL stall_write%0d: got cyc=%0d addr=%h want cyc=%0d", i, wr_cyc[i], wr_adr[i], e_wr[i]);
         end
      end
      checks++;
      if (done_cyc.size() !== 1 || done_cyc[0] !== 11) begin
         failures++;
         $display("FAIL stall_done: got n=%0d at %0d want 1 at 11", done_cyc.size(), done_cyc[0]);
      end
   endtask

   task automatic test_zero_len();
      run_job(0, 16'h0040, 16'h0050, 3'd5, 16'd9, 16'd4, 1'b0, 64'h0, 8);
      checks++;
      if (rs_cyc.size() !== 1 || rs_cyc[0] !== 1) begin
         failures++;
         $display("FAIL zero_load: got %0d pulses first=%0d want 1 at 1", rs_cyc.size(), rs_cyc[0]);
      end
      checks++;
      if (done_cyc.size() !== 1 || done_cyc[0] !== 2 || ready_cyc !== 3) begin
         failures++;
         $display("FAIL zero_done: got n=%0d at %0d ready %0d want done 2 ready 3",
                  done_cyc.size(), done_cyc[0], ready_cyc);
      end
      checks++;
      if (rd_cyc.size() !== 0 || wr_cyc.size() !== 0 || fv_cyc.size() !== 0) begin
         failures++;
         $display("FAIL zero_traffic: got rd=%0d wr=%0d fv=%0d want 0", rd_cyc.size(), wr_cyc.size(), fv_cyc.size());
      end
   endtask

   task automatic test_wrap();
      logic [15:0] e_ra[3] = '{16'hFFFE, 16'hFFFF, 16'h0000};
      logic [15:0] e_wa[3] = '{16'hFFFF, 16'h0000, 16'h0001};
      run_job(3, 16'hFFFE, 16'hFFFF, 3'd4, 16'hFFF0, 16'd3, 1'b0, 64'h0, 12);
      checks++;
      if (rd_cyc.size() !== 3 || wr_cyc.size() !== 3) begin
         failures++;
         $display("FAIL wrap_counts: got rd=%0d wr=%0d want 3/3", rd_cyc.size(), wr_cyc.size());
      end
      for (int i = 0; i < 3 && i < rd_adr.size() && i < wr_adr.size(); i++) begin
         checks++;
         if (rd_adr[i] !== e_ra[i] || wr_adr[i] !== e_wa[i]) begin
            failures++;
            $display("FAIL wrap_addr%0d: got rd=%h wr=%h want rd=%h wr=%h", i, rd_adr[i], wr_adr[i], e_ra[i], e_wa[i]);
         end
      end
      checks++;
      if (done_cyc.size() !== 1 || done_cyc[0] !== 8 || attr_bad !== 0) begin
         failures++;
         $display("FAIL wrap_done: got n=%0d at %0d bad=%0d want done 8", done_cyc.size(), done_cyc[0], attr_bad);
      end
   endtask

   task automatic test_reset_mid_job();
      int late_events;
      @(negedge clk);
      cfg_fn = 3'd3; cfg_imm = 16'd5; cfg_rshift = 16'd2; cfg_8bit = 1'b1;
      cfg_num = 16'd8; cfg_rd_base = 16'h0100; cfg_wr_base = 16'h0200;
      cfg_valid = 1'b1;
      @(posedge clk);
      #1 cfg_valid = 1'b0;
      repeat (3) @(posedge clk);
      #1 reset = 1'b1;
      #1;
      checks++;
      if ({obuf_rd_req, obuf_rd_addr, alu_fn_valid, alu_fn, alu_imm, alu_choose_8bit,
           alu_cfg_rs_num_v, alu_rshift_num, obuf_wr_en, obuf_wr_addr, busy, done} !== '0
          || cfg_ready !== 1'b1) begin
         failures++;
         $display("FAIL midreset_outputs: got rd=%b fv=%b busy=%b ready=%b fn=%0d want zeros ready=1",
                  obuf_rd_req, alu_fn_valid, busy, cfg_ready, alu_fn);
      end
      @(negedge clk);
      reset = 1'b0;
      late_events = 0;
      repeat (12) begin
         @(negedge clk);
         if (done || obuf_wr_en || obuf_rd_req || busy) late_events++;
      end
      checks++;
      if (late_events !== 0) begin
         failures++;
         $display("FAIL midreset_quiet: got %0d active cycles want 0", late_events);
      end
      run_job(2, 16'h0030, 16'h0060, 3'd4, 16'd1, 16'd0, 1'b0, 64'h0, 10);
      checks++;
      if (rd_cyc.size() !== 2 || rd_cyc[0] !== 2 || rd_cyc[1] !== 3 || rd_adr[1] !== 16'h0031) begin
         failures++;
         $display("FAIL midreset_next_reads: got n=%0d first=%0d want cycles 2,3", rd_cyc.size(), rd_cyc[0]);
      end
      checks++;
      if (wr_cyc.size() !== 2 || wr_cyc[0] !== 5 || wr_cyc[1] !== 6 || wr_adr[0] !== 16'h0060
          || done_cyc.size() !== 1 || done_cyc[0] !== 7) begin
         failures++;
         $display("FAIL midreset_next_writes: got wr=%0d first=%0d done=%0d want wr 5,6 done 7",
                  wr_cyc.size(), wr_cyc[0], done_cyc[0]);
      end
   endtask

   task automatic test_back_to_back();
      int fn_bad;
      int ready_n;
      int ready_at;
      int waited;
      rs_cyc.delete(); done_cyc.delete();
      fn_bad = 0; ready_n = 0; ready_at = -1;
      @(negedge clk);
      cfg_fn = 3'd3; cfg_imm = 16'd2; cfg_rshift = 16'd1; cfg_8bit = 1'b0;
      cfg_num = 16'd2; cfg_rd_base = 16'h0000; cfg_wr_base = 16'h0010;
      cfg_valid = 1'b1;
      @(posedge clk);
      #1;
      cfg_fn = 3'd5; cfg_imm = 16'd7; cfg_num = 16'd1;
      for (int k = 1; k <= 12; k++) begin
         @(negedge clk);
         if (alu_cfg_rs_num_v) rs_cyc.push_back(k);
         if (done) done_cyc.push_back(k);
         if (cfg_ready) begin ready_n++; ready_at = k; end
         if (k <= 8 && (alu_fn !== 3'd3 || alu_imm !== 16'd2)) fn_bad++;
         if (k >= 9 && (alu_fn !== 3'd5 || alu_imm !== 16'd7)) fn_bad++;
         @(posedge clk);
         #1;
      end
      cfg_valid = 1'b0;
      checks++;
      if (rs_cyc.size() !== 2 || rs_cyc[0] !== 1 || rs_cyc[1] !== 9) begin
         failures++;
         $display("FAIL b2b_accept: got n=%0d second=%0d want loads at 1 and 9", rs_cyc.size(), rs_cyc[1]);
      end
      checks++;
      if (ready_n !== 1 || ready_at !== 8 || done_cyc.size() !== 1 || done_cyc[0] !== 7) begin
         failures++;
         $display("FAIL b2b_ready: got ready n=%0d at %0d done at %0d want ready 8 done 7",
                  ready_n, ready_at, done_cyc[0]);
      end
      checks++;
      if (fn_bad !== 0) begin
         failures++;
         $display("FAIL b2b_fn_switch: got %0d wrong cycles want 0", fn_bad);
      end
      waited = 0;
      while (!cfg_ready && waited < 30) begin
         @(negedge clk);
         waited++;
      end
      checks++;
      if (cfg_ready !== 1'b1) begin
         failures++;
         $display("FAIL b2b_finish: got ready=%b after %0d cycles want 1", cfg_ready, waited);
      end
   endtask

   initial begin
      #300000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      test_reset();
      test_basic();
      test_stall();
      test_zero_len();
      test_wrap();
      test_reset_mid_job();
      test_back_to_back();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
